// File: rtl/vram_arbiter_if.sv
// Bundle of the display, writer and VRAM macro signals seen by vram_arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory side.
interface vram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;

  logic              w0_req;
  logic              w0_we;
  logic [ADDR_W-1:0] w0_addr;
  logic [DATA_W-1:0] w0_wdata;
  logic              w0_gnt;
  logic [DATA_W-1:0] w0_rdata;
  logic              w0_rvalid;

  logic              w1_req;
  logic              w1_we;
  logic [ADDR_W-1:0] w1_addr;
  logic [DATA_W-1:0] w1_wdata;
  logic              w1_gnt;
  logic [DATA_W-1:0] w1_rdata;
  logic              w1_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr,
    output disp_rdata, disp_rvalid,
    input  w0_req, w0_we, w0_addr, w0_wdata,
    output w0_gnt, w0_rdata, w0_rvalid,
    input  w1_req, w1_we, w1_addr, w1_wdata,
    output w1_gnt, w1_rdata, w1_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output disp_req, disp_addr,
    input  disp_rdata, disp_rvalid,
    output w0_req, w0_we, w0_addr, w0_wdata,
    input  w0_gnt, w0_rdata, w0_rvalid,
    output w1_req, w1_we, w1_addr, w1_wdata,
    input  w1_gnt, w1_rdata, w1_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out has absolute priority, the two
// writer ports share the remaining cycles round-robin in bursts of up to BURST.
//
// state | meaning
// IDLE  | no writer owns the memory; arbitrate among requesting writers
// OWN0  | writer 0 owns the memory for the current burst
// OWN1  | writer 1 owns the memory for the current burst
module vram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int BURST  = 4
) (
  input logic           clk,
  input logic           rst_n,
  vram_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_DISP = 2'd1;
  localparam logic [1:0] T_W0   = 2'd2;
  localparam logic [1:0] T_W1   = 2'd3;

  localparam int             CW       = $clog2(BURST + 1);
  localparam logic [CW-1:0]  BURST_C  = CW'(BURST);
  localparam bit             ONE_SHOT = (BURST == 1);

  logic [1:0]        state, nxt_state;
  logic              last, nxt_last;
  logic [CW-1:0]     bcnt, nxt_bcnt;
  logic [1:0]        rtag, nxt_rtag;
  logic [DATA_W-1:0] hold_disp, hold_w0, hold_w1;

  logic              owned, own_id, own_req;
  logic [CW-1:0]     bcnt_inc;
  logic              eff_last, win1;
  logic              disp_acc, gnt0, gnt1;

  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign owned    = (state == S_OWN0) || (state == S_OWN1);
  assign own_id   = (state == S_OWN1);
  assign own_req  = own_id ? bus.w1_req : bus.w0_req;
  assign bcnt_inc = bcnt + CW'(1);

  // Grants are combinational so a free memory is handed out with no wait.
  // Everything is gated by rst_n so outputs stay quiet while reset is held.
  always_comb begin
    nxt_state = state;
    nxt_last  = last;
    nxt_bcnt  = bcnt;
    eff_last  = last;
    win1      = 1'b0;
    disp_acc  = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (rst_n) begin
      if (bus.disp_req) begin
        disp_acc = 1'b1;
      end else if (owned && own_req) begin
        gnt0 = !own_id;
        gnt1 = own_id;
        if (bcnt_inc == BURST_C) begin
          nxt_state = S_IDLE;
          nxt_last  = own_id;
          nxt_bcnt  = '0;
        end else begin
          nxt_bcnt  = bcnt_inc;
        end
      end else begin
        // A dropped request releases ownership and the freed cycle is
        // re-arbitrated right away, so the other writer loses no cycle.
        eff_last  = owned ? own_id : last;
        nxt_last  = eff_last;
        nxt_state = S_IDLE;
        nxt_bcnt  = '0;
        if (bus.w0_req || bus.w1_req) begin
          win1 = (bus.w0_req && bus.w1_req) ? !eff_last : bus.w1_req;
          gnt0 = !win1;
          gnt1 = win1;
          if (ONE_SHOT) begin
            nxt_last = win1;
          end else begin
            nxt_state = win1 ? S_OWN1 : S_OWN0;
            nxt_bcnt  = CW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    nxt_rtag  = T_NONE;
    if (disp_acc) begin
      mem_en   = 1'b1;
      mem_addr = bus.disp_addr;
      nxt_rtag = T_DISP;
    end else if (gnt0) begin
      mem_en    = 1'b1;
      mem_we    = bus.w0_we;
      mem_addr  = bus.w0_addr;
      mem_wdata = bus.w0_we ? bus.w0_wdata : '0;
      nxt_rtag  = bus.w0_we ? T_NONE : T_W0;
    end else if (gnt1) begin
      mem_en    = 1'b1;
      mem_we    = bus.w1_we;
      mem_addr  = bus.w1_addr;
      mem_wdata = bus.w1_we ? bus.w1_wdata : '0;
      nxt_rtag  = bus.w1_we ? T_NONE : T_W1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      last      <= 1'b1;
      bcnt      <= '0;
      rtag      <= T_NONE;
      hold_disp <= '0;
      hold_w0   <= '0;
      hold_w1   <= '0;
    end else begin
      state <= nxt_state;
      last  <= nxt_last;
      bcnt  <= nxt_bcnt;
      rtag  <= nxt_rtag;
      if (rtag == T_DISP) hold_disp <= bus.mem_rdata;
      if (rtag == T_W0)   hold_w0   <= bus.mem_rdata;
      if (rtag == T_W1)   hold_w1   <= bus.mem_rdata;
    end
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  assign bus.w0_gnt = gnt0;
  assign bus.w1_gnt = gnt1;

  // Read data passes straight through in the response cycle, otherwise the
  // last delivered value is replayed.
  assign bus.disp_rvalid = (rtag == T_DISP);
  assign bus.w0_rvalid   = (rtag == T_W0);
  assign bus.w1_rvalid   = (rtag == T_W1);
  assign bus.disp_rdata  = (rtag == T_DISP) ? bus.mem_rdata : hold_disp;
  assign bus.w0_rdata    = (rtag == T_W0)   ? bus.mem_rdata : hold_w0;
  assign bus.w1_rdata    = (rtag == T_W1)   ? bus.mem_rdata : hold_w1;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a priority/round-robin reference model
// predicts every cycle's memory access and every read response.
module tb_vram_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int BURST  = 4;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  typedef struct {
    int                cyc;
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              g0;
    logic              g1;
  } cyc_exp_t;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst_n;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // VRAM macro stand-in: read data valid the cycle after a read access.
  logic [DATA_W-1:0] vram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] mem_q;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
      else            mem_q <= vram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = mem_q;

  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  txn_t      wq [2][$];
  rd_exp_t   rq [3][$];
  cyc_exp_t  ce_q [$];
  logic [DATA_W-1:0] held [3];
  string     pname [3] = '{"disp", "w0", "w1"};

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  bit                rst_plan = 1'b0;
  bit                disp_plan = 1'b0;
  logic [ADDR_W-1:0] disp_addr_plan = '0;

  // Reference model state: who owns the memory, how long, who had it last.
  int m_owner, m_run, m_last;

  function automatic void model_reset();
    m_owner = -1;
    m_run   = 0;
    m_last  = 1;
  endfunction

  // Returns -2 for no access, -1 for display, 0/1 for the writer granted.
  function automatic int model_pick(bit d, bit r0, bit r1);
    bit req [2];
    int g;
    req[0] = r0;
    req[1] = r1;
    if (d) return -1;
    if (m_owner >= 0 && req[m_owner]) begin
      g = m_owner;
      m_run++;
      if (m_run == BURST) begin
        m_last  = m_owner;
        m_owner = -1;
      end
      return g;
    end
    if (m_owner >= 0) begin
      m_last  = m_owner;
      m_owner = -1;
    end
    if (r0 && r1)  g = 1 - m_last;
    else if (r0)   g = 0;
    else if (r1)   g = 1;
    else           return -2;
    m_owner = g;
    m_run   = 1;
    if (m_run == BURST) begin
      m_last  = g;
      m_owner = -1;
    end
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = ADDR_W'($urandom_range(0, 63));
    t.wdata = DATA_W'($urandom);
    return t;
  endfunction

  task automatic tick();
    cyc_exp_t e;
    txn_t     t;
    bit       r0, r1;
    int       g;
    @(posedge clk);
    #1;
    cyc++;
    rst_n         = rst_plan;
    bus.disp_req  = disp_plan;
    bus.disp_addr = disp_addr_plan;
    r0 = (wq[0].size() > 0);
    r1 = (wq[1].size() > 0);
    bus.w0_req = r0;
    bus.w1_req = r1;
    t = r0 ? wq[0][0] : '0;
    bus.w0_we = t.we; bus.w0_addr = t.addr; bus.w0_wdata = t.wdata;
    t = r1 ? wq[1][0] : '0;
    bus.w1_we = t.we; bus.w1_addr = t.addr; bus.w1_wdata = t.wdata;
    e = '{cyc: cyc, en: 1'b0, we: 1'b0, addr: '0, wdata: '0, g0: 1'b0, g1: 1'b0};
    if (!rst_plan) begin
      model_reset();
      for (int p = 0; p < 3; p++) begin
        rq[p].delete();
        held[p] = '0;
      end
    end else begin
      g = model_pick(disp_plan, r0, r1);
      if (g == -1) begin
        e.en   = 1'b1;
        e.addr = disp_addr_plan;
        rq[0].push_back('{cyc: cyc + 1, data: ref_mem[disp_addr_plan]});
      end else if (g >= 0) begin
        t      = wq[g].pop_front();
        e.en   = 1'b1;
        e.we   = t.we;
        e.addr = t.addr;
        e.g0   = (g == 0);
        e.g1   = (g == 1);
        if (t.we) begin
          e.wdata         = t.wdata;
          ref_mem[t.addr] = t.wdata;
        end else begin
          rq[g+1].push_back('{cyc: cyc + 1, data: ref_mem[t.addr]});
        end
      end
    end
    ce_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: compares whatever the DUT presents against queued expectations.
  initial begin
    cyc_exp_t e;
    rd_exp_t  x;
    logic     v;
    logic [DATA_W-1:0] d;
    forever begin
      @(negedge clk);
      if (ce_q.size() > 0) begin
        e = ce_q.pop_front();
        chk("gnt", {30'd0, bus.w1_gnt, bus.w0_gnt}, {30'd0, e.g1, e.g0});
        chk("mem_en", 32'(bus.mem_en), 32'(e.en));
        chk("mem_we", 32'(bus.mem_we), 32'(e.we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
        if (!e.en || e.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
      end
      for (int p = 0; p < 3; p++) begin
        case (p)
          0:       begin v = bus.disp_rvalid; d = bus.disp_rdata; end
          1:       begin v = bus.w0_rvalid;   d = bus.w0_rdata;   end
          default: begin v = bus.w1_rvalid;   d = bus.w1_rdata;   end
        endcase
        if (v) begin
          if (rq[p].size() == 0) begin
            chk({pname[p], "_spurious_rvalid"}, 32'(v), 32'd0);
          end else begin
            x = rq[p].pop_front();
            chk({pname[p], "_rdata"}, 32'(d), 32'(x.data));
            chk({pname[p], "_rvalid_cycle"}, 32'(cyc), 32'(x.cyc));
            held[p] = x.data;
          end
        end else begin
          chk({pname[p], "_rdata_hold"}, 32'(d), 32'(held[p]));
          if (rq[p].size() > 0 && rq[p][0].cyc <= cyc) begin
            chk({pname[p], "_missing_rvalid"}, 32'(v), 32'd1);
            void'(rq[p].pop_front());
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      vram[i]    = '0;
      ref_mem[i] = '0;
    end
    mem_q = '0;
    for (int p = 0; p < 3; p++) held[p] = '0;
    model_reset();
    rst_n = 1'b0;
    bus.disp_req = 1'b0; bus.disp_addr = '0;
    bus.w0_req = 1'b0; bus.w0_we = 1'b0; bus.w0_addr = '0; bus.w0_wdata = '0;
    bus.w1_req = 1'b0; bus.w1_we = 1'b0; bus.w1_addr = '0; bus.w1_wdata = '0;

    // Reset with every requester active, then continuous dual-writer bursts.
    for (int i = 0; i < 12; i++) begin
      wq[0].push_back('{we: 1'b1, addr: ADDR_W'(32'h100 + i), wdata: DATA_W'($urandom)});
      wq[1].push_back('{we: 1'b1, addr: ADDR_W'(32'h200 + i), wdata: DATA_W'($urandom)});
    end
    rst_plan  = 1'b0;
    disp_plan = 1'b1;
    run(3);
    rst_plan  = 1'b1;
    disp_plan = 1'b0;
    run(26);

    // Display steals three cycles from a waiting writer.
    wq[0].push_back('{we: 1'b1, addr: 15'h300, wdata: 8'h3C});
    disp_plan = 1'b1;
    for (int i = 0; i < 3; i++) begin
      disp_addr_plan = ADDR_W'(32'h100 + i);
      tick();
    end
    disp_plan = 1'b0;
    run(3);

    // Early release: short w0 run while w1 keeps asking.
    wq[0].push_back('{we: 1'b1, addr: 15'h10, wdata: 8'h11});
    wq[0].push_back('{we: 1'b1, addr: 15'h11, wdata: 8'h22});
    for (int i = 0; i < 6; i++)
      wq[1].push_back('{we: 1'b0, addr: ADDR_W'(32'h10 + (i % 2)), wdata: 8'h00});
    run(10);

    // Read-after-write on w1.
    wq[1].push_back('{we: 1'b1, addr: 15'h1234, wdata: 8'hA5});
    wq[1].push_back('{we: 1'b0, addr: 15'h1234, wdata: 8'h00});
    run(4);

    // Reset in the cycle after a w1 read, then a tie.
    wq[1].push_back('{we: 1'b0, addr: 15'h1234, wdata: 8'h00});
    wq[1].push_back('{we: 1'b0, addr: 15'h100, wdata: 8'h00});
    run(1);
    rst_plan = 1'b0;
    run(1);
    rst_plan = 1'b1;
    wq[0].push_back('{we: 1'b0, addr: 15'h1234, wdata: 8'h00});
    run(6);

    // Randomized mix of display bursts, writer traffic and rare resets.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++)
        if (wq[k].size() < 3 && $urandom_range(0, 2) != 0) wq[k].push_back(rand_txn());
      disp_plan      = ($urandom_range(0, 3) == 0);
      disp_addr_plan = ADDR_W'($urandom_range(0, 63));
      rst_plan       = ($urandom_range(0, 599) != 0);
      tick();
    end

    rst_plan  = 1'b1;
    disp_plan = 1'b0;
    for (int i = 0; i < 200 && (wq[0].size() + wq[1].size()) > 0; i++) tick();
    run(3);
    @(negedge clk);
    #1;
    chk("writer_drain", 32'(wq[0].size() + wq[1].size()), 32'd0);
    for (int p = 0; p < 3; p++)
      chk({pname[p], "_pending_reads"}, 32'(rq[p].size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
